// File: rtl/led_chaser.sv
// led_chaser: four-LED pattern sequencer. A prescaler produces a step tick;
// each tick advances the current display pattern, and after MODE_STEPS
// ticks the block moves on to the next of four pattern modes, forever.
module led_chaser #(
    parameter int unsigned STEP_TICKS = 50,
    parameter int unsigned MODE_STEPS = 16,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rstn,
    output logic [3:0] led_c
);

    typedef enum logic [1:0] {
        ModeShl    = 2'd0,
        ModeShr    = 2'd1,
        ModeBounce = 2'd2,
        ModeCount  = 2'd3
    } mode_e;

    localparam logic [15:0] TICK_LAST = 16'(STEP_TICKS - 1);
    localparam logic [7:0]  STEP_LAST = 8'(MODE_STEPS - 1);
    localparam logic [3:0]  PAT_RST   = 4'b0001;
    localparam logic [3:0]  LED_RST   = ACTIVE_LOW ? ~PAT_RST : PAT_RST;

    logic [15:0] tick_q, tick_d;
    logic [7:0]  step_q, step_d;
    mode_e       mode_q, mode_d;
    logic [3:0]  pat_q, pat_d;
    logic        dir_q, dir_d;   // 1 = moving towards bit 3 in bounce mode
    logic [3:0]  led_q;

    // State registers; led_q is loaded from the next pattern so the pins
    // come straight off a flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_q <= '0;
            step_q <= '0;
            mode_q <= ModeShl;
            pat_q  <= PAT_RST;
            dir_q  <= 1'b1;
            led_q  <= LED_RST;
        end else begin
            tick_q <= tick_d;
            step_q <= step_d;
            mode_q <= mode_d;
            pat_q  <= pat_d;
            dir_q  <= dir_d;
            led_q  <= ACTIVE_LOW ? ~pat_d : pat_d;
        end
    end

    // Next-state: prescaler, step counter, mode switch and pattern update.
    always_comb begin
        tick_d = tick_q;
        step_d = step_q;
        mode_d = mode_q;
        pat_d  = pat_q;
        dir_d  = dir_q;
        if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (step_q == STEP_LAST) begin
                step_d = '0;
                mode_d = mode_e'(mode_q + 2'd1);
                unique case (mode_d)
                    ModeShl:    pat_d = 4'b0001;
                    ModeShr:    pat_d = 4'b1000;
                    ModeBounce: begin
                        pat_d = 4'b0001;
                        dir_d = 1'b1;
                    end
                    ModeCount:  pat_d = 4'b0000;
                endcase
            end else begin
                step_d = step_q + 8'd1;
                unique case (mode_q)
                    ModeShl: pat_d = {pat_q[2:0], pat_q[3]};
                    ModeShr: pat_d = {pat_q[0], pat_q[3:1]};
                    ModeBounce: begin
                        // Flip direction on reaching an end so it is never shown twice.
                        if (dir_q) begin
                            pat_d = {pat_q[2:0], 1'b0};
                            if (pat_d == 4'b1000) dir_d = 1'b0;
                        end else begin
                            pat_d = {1'b0, pat_q[3:1]};
                            if (pat_d == 4'b0001) dir_d = 1'b1;
                        end
                    end
                    ModeCount: pat_d = pat_q + 4'd1;
                endcase
            end
        end else begin
            tick_d = tick_q + 16'd1;
        end
    end

    assign led_c = led_q;

endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser: five instances with different parameters share one
// clock and reset; expected LED values come from a closed-form model of the
// pattern sequence indexed by rising edges since reset release.
module tb_led_chaser;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] led_a, led_b, led_cc, led_d, led_e;

    int total = 0;
    int bad   = 0;
    int n     = 0;   // rising edges since reset release

    led_chaser u_a (.clk(clk), .rstn(rstn), .led_c(led_a));
    led_chaser #(.STEP_TICKS(2), .MODE_STEPS(16), .ACTIVE_LOW(1'b0))
        u_b (.clk(clk), .rstn(rstn), .led_c(led_b));
    led_chaser #(.STEP_TICKS(1), .MODE_STEPS(8), .ACTIVE_LOW(1'b0))
        u_c (.clk(clk), .rstn(rstn), .led_c(led_cc));
    led_chaser #(.STEP_TICKS(1), .MODE_STEPS(20), .ACTIVE_LOW(1'b0))
        u_d (.clk(clk), .rstn(rstn), .led_c(led_d));
    led_chaser #(.STEP_TICKS(3), .MODE_STEPS(4), .ACTIVE_LOW(1'b1))
        u_e (.clk(clk), .rstn(rstn), .led_c(led_e));

    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        logic [3:0] exp;
    } vec_t;

    vec_t       tbl [9];
    logic [3:0] seq_shl    [17] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b1000};
    logic [3:0] seq_bounce [8]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0100, 4'b0010, 4'b0001, 4'b0010};

    // Expected LED value after n edges: steps elapsed select mode and
    // position within the mode.
    function automatic logic [3:0] model(int st, int ms, bit al, int edges);
        int steps, mode, k, b;
        logic [3:0] p;
        steps = edges / st;
        mode  = (steps / ms) % 4;
        k     = steps % ms;
        case (mode)
            0:       p = 4'b0001 << (k % 4);
            1:       p = 4'b1000 >> (k % 4);
            2: begin
                b = k % 6;
                p = (b < 4) ? (4'b0001 << b) : (4'b0001 << (6 - b));
            end
            default: p = 4'(k % 16);
        endcase
        return al ? ~p : p;
    endfunction

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %b want %b", name, n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic check_all();
        chk("mdl_a", led_a,  model(50, 16, 1'b0, n));
        chk("mdl_b", led_b,  model(2, 16, 1'b0, n));
        chk("mdl_c", led_cc, model(1, 8, 1'b0, n));
        chk("mdl_d", led_d,  model(1, 20, 1'b0, n));
        chk("mdl_e", led_e,  model(3, 4, 1'b1, n));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_a"}, led_a,  4'b0001);
        chk({tag, "_b"}, led_b,  4'b0001);
        chk({tag, "_c"}, led_cc, 4'b0001);
        chk({tag, "_d"}, led_d,  4'b0001);
        chk({tag, "_e"}, led_e,  4'b1110);
    endtask

    // Assert reset now (between edges), hold, release on a falling edge.
    task automatic do_reset(input int hold);
        rstn = 1'b0;
        #1;
        check_reset("rst_async");
        #(hold);
        check_reset("rst_hold");
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
    endtask

    initial begin
        tbl = '{'{0, 4'b0001}, '{49, 4'b0001}, '{50, 4'b0010}, '{100, 4'b0100},
                '{800, 4'b1000}, '{850, 4'b0100}, '{1650, 4'b0010},
                '{2400, 4'b0000}, '{3150, 4'b1111}};

        // Reset held for two cycles, then release with default parameters.
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst_init");
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            while (n < tbl[i].edge_n) step();
            chk($sformatf("tbl%0d", i), led_a, tbl[i].exp);
        end
        while (n < 3200) step();
        chk("full_cycle", led_a, 4'b0001);

        // Mode sequences for the short-period instances.
        do_reset(12);
        for (int e = 0; e <= 80; e++) begin
            if (e > 0) step();
            if (e % 2 == 0 && e <= 32) chk("shl_seq", led_b, seq_shl[e / 2]);
            if (e >= 16 && e < 24) chk("bounce_seq", led_cc, seq_bounce[e - 16]);
            if (e >= 24 && e < 32) chk("count8_seq", led_cc, 4'(e - 24));
            if (e == 32) chk("wrap8_mode0", led_cc, 4'b0001);
            if (e >= 60 && e < 80) chk("count20_seq", led_d, 4'((e - 60) % 16));
            if (e == 80) chk("wrap20_mode0", led_d, 4'b0001);
            if (e == 2) chk("al_pre_tick", led_e, 4'b1110);
            if (e == 3) chk("al_first_tick", led_e, 4'b1101);
            if (e == 35) chk("al_bounce_end", led_e, 4'b0111);
            if (e == 36) chk("al_count_zero", led_e, 4'b1111);
        end

        // Short asynchronous reset pulse between edges, mid bounce mode.
        do_reset(12);
        while (n < 18) step();
        chk("pre_pulse_c", led_cc, 4'b0100);
        #2;
        rstn = 1'b0;
        #1;
        chk("pulse_c", led_cc, 4'b0001);
        chk("pulse_a", led_a, 4'b0001);
        chk("pulse_e", led_e, 4'b1110);
        #2;
        rstn = 1'b1;
        n = 0;
        step();
        chk("post_pulse_c", led_cc, 4'b0010);
        chk("post_pulse_e", led_e, 4'b1110);
        while (n < 49) step();
        chk("post_pulse_a49", led_a, 4'b0001);
        step();
        chk("post_pulse_a50", led_a, 4'b0010);

        // Random run lengths with random asynchronous resets, model-checked.
        do_reset(7);
        check_all();
        for (int it = 0; it < 30; it++) begin
            int len;
            len = int'($urandom_range(300, 1));
            repeat (len) begin
                step();
                check_all();
            end
            if ($urandom_range(1, 0) == 1) begin
                #($urandom_range(3, 0));
                do_reset(int'($urandom_range(25, 1)));
                check_all();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_chaser.md
# led_chaser

Four-LED pattern sequencer driven from a single slow system clock (nominally 100 Hz, 10 ms period). A programmable prescaler produces a step tick. On each tick the 4-bit LED output advances through one of four display patterns. After a fixed number of steps the block moves to the next pattern mode, cycling forever. It sits at board level and drives the LED pins directly; there are no other inputs.

## Interface
- STEP_TICKS, default 50: clock cycles per display step (0.5 s at 100 Hz). Legal range 1..65535.
- MODE_STEPS, default 16: display steps spent in each mode before switching. Legal range 1..255.
- ACTIVE_LOW, default 0: when 1, led_c is bitwise inverted at the output (pattern bit 1 drives 0).
- clk  input  1  system clock; all logic is on the rising edge.
- rstn  input  1  reset. One clock; reset is asynchronous and active-low.
- led_c  output  4  LED drive, registered; bit 0 is the rightmost LED.

## Operation
- Internal state:
  - tick_cnt counts 0..STEP_TICKS-1.
  - step_cnt counts 0..MODE_STEPS-1.
  - mode is 2 bits.
  - pat is 4 bits.
  - dir is 1 bit, used for bounce.
- Reset (rstn=0): tick_cnt=0, step_cnt=0, mode=0, dir=up, pat=4'b0001. led_c=4'b0001 (4'b1110 if ACTIVE_LOW).
- Step tick: fires on the edge where tick_cnt==STEP_TICKS-1; on that edge tick_cnt wraps to 0. With STEP_TICKS=1 a tick fires on every edge.
- On a tick with step_cnt<MODE_STEPS-1, step_cnt increments and pat advances within the current mode:
  - Mode 0, shift-left: rotate left. 0001→0010→0100→1000→0001.
  - Mode 1, shift-right: rotate right. 1000→0100→0010→0001→1000.
  - Mode 2, bounce: one-hot moves left to 1000, then right to 0001, then repeats. Sequence 0001,0010,0100,1000,0100,0010,0001,… (period 6). dir flips at either end; an end value is never repeated.
  - Mode 3, binary count: pat+1 modulo 16, wrapping 1111→0000.
- On a tick with step_cnt==MODE_STEPS-1 (mode switch):
  - step_cnt=0 and mode=mode+1 modulo 4.
  - pat loads the first pattern of the new mode: mode0 0001, mode1 1000, mode2 0001 (dir=up), mode3 0000.
- led_c = pat, or ~pat when ACTIVE_LOW. It is taken straight from the register with no combinational logic after it.
- Outside mode 3, exactly one bit of pat is set at all times.

## Timing
- Asynchronous assertion: led_c takes its reset value immediately on rstn falling, with no clock needed.
- Deassertion: the first rising edge with rstn=1 counts as tick_cnt 0→1.
- First pattern change: led_c first changes on the STEP_TICKS-th rising edge after release (edge 50 by default, i.e. 500 ms at 100 Hz).
- Step period: exactly STEP_TICKS cycles.
- Mode period: STEP_TICKS*MODE_STEPS cycles (800 by default).
- Full 4-mode cycle: 4*STEP_TICKS*MODE_STEPS cycles (3200 by default).
- Reset mid-operation: all state returns to reset values regardless of mode or count. The sequence restarts from mode 0 / 0001 after release.
- No glitches: led_c changes only on rising clk edges, outside of reset.

## Test plan
- Reset hold and release, defaults:
  - Hold rstn=0 for 2 cycles → led_c=0001.
  - Release → led_c stays 0001 through edge 49 and becomes 0010 on edge 50.
- Mode 0 sequence, STEP_TICKS=2, MODE_STEPS=16:
  - Sample led_c after every tick → 0001,0010,0100,1000 repeated 4 times.
  - Then mode 1 begins with 1000 at step 16.
- Bounce and wrap, STEP_TICKS=1, MODE_STEPS=8:
  - Mode 2 outputs 0001,0010,0100,1000,0100,0010,0001,0010.
  - Mode 3 outputs 0000..0111.
  - Then mode 0 restarts at 0001.
- Binary wrap, STEP_TICKS=1, MODE_STEPS=20:
  - Mode 3 counts 0000..1111, then 0000..0011.
  - Then mode 0 restarts at 0001.
- Asynchronous reset mid-mode:
  - Pulse rstn low for 3 ms, between clock edges, during mode 2 with pat=0100 → led_c=0001 immediately, before the next edge.
  - After release, the first change occurs STEP_TICKS edges later.
- ACTIVE_LOW=1:
  - Reset → led_c=1110.
  - After the first tick → led_c=1101.
  - In mode 3, a count of 0000 drives led_c=1111.
